// File: rtl/pc_seq_if.sv
// Handshake bundle between the fetch PC sequencer and the decode/hazard/imem logic.
// The slave modport is the sequencer's view; master is the surrounding pipeline's view.
interface pc_seq_if;
  logic        stall;
  logic        imem_ready;
  logic        branch_valid;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt_dec;
  logic        cnt_clear;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        if_id_write;
  logic        if_id_flush;
  logic        halted;
  logic [15:0] taken_count;

  modport master (
    output stall, imem_ready, branch_valid, branch_taken, branch_target, halt_dec, cnt_clear,
    input  pc_out, pc_plus2, if_id_write, if_id_flush, halted, taken_count
  );

  modport slave (
    input  stall, imem_ready, branch_valid, branch_taken, branch_target, halt_dec, cnt_clear,
    output pc_out, pc_plus2, if_id_write, if_id_flush, halted, taken_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register and next-PC sequencing around the decode-stage branch resolver.
// Buffers redirects that arrive while imem is busy, drives IF/ID flush/write, counts taken branches.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic     clk,
  input  logic     rst,
  pc_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_PEND = 2'd1,
    HALTED     = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] pend_pc_q;
  logic [15:0] taken_count_q;
  logic [1:0]  flush_cnt_q;
  logic        halted_q;

  logic        redirect_req;
  logic        halt_req;
  logic        apply_redirect;
  logic [15:0] apply_pc;

  assign redirect_req = bus.branch_valid & bus.branch_taken & ~bus.stall & ~halted_q;
  assign halt_req     = bus.halt_dec & ~bus.stall & ~redirect_req;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    apply_redirect = 1'b0;
    apply_pc       = bus.branch_target;
    case (state_q)
      RUN:        apply_redirect = redirect_req & bus.imem_ready;
      REDIR_PEND: begin
        apply_redirect = bus.imem_ready;
        apply_pc       = pend_pc_q;
      end
      default:    apply_redirect = 1'b0;
    endcase
  end

  // NOTE: state uses non-blocking assignments only; async reset clears every register, pend_pc included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      pend_pc_q     <= 16'h0000;
      taken_count_q <= 16'h0000;
      flush_cnt_q   <= 2'd0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect_req && !bus.imem_ready) begin
            pend_pc_q <= bus.branch_target;
            state_q   <= REDIR_PEND;
          end else if (apply_redirect) begin
            pc_q <= apply_pc;
          end else if (halt_req) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (!bus.stall && bus.imem_ready) begin
            pc_q <= pc_q + 16'd2;
          end
        end
        REDIR_PEND: begin
          if (apply_redirect) begin
            pc_q    <= apply_pc;
            state_q <= RUN;
          end
        end
        default: begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
      endcase

      // A redirect landing inside an active flush window simply restarts it.
      if (apply_redirect)          flush_cnt_q <= FLUSH_RELOAD;
      else if (flush_cnt_q != 2'd0) flush_cnt_q <= flush_cnt_q - 2'd1;

      // Clear beats a same-cycle increment; the count sticks at all-ones.
      if (bus.cnt_clear)                                  taken_count_q <= 16'h0000;
      else if (apply_redirect && taken_count_q != 16'hFFFF) taken_count_q <= taken_count_q + 16'd1;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_plus2    = pc_q + 16'd2;
  assign bus.halted      = halted_q;
  assign bus.taken_count = taken_count_q;
  assign bus.if_id_flush = redirect_req | (state_q == REDIR_PEND) | (flush_cnt_q != 2'd0);
  assign bus.if_id_write = bus.if_id_flush | (~bus.stall & bus.imem_ready & ~halted_q);

endmodule
